// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types and widths.
package uart_pkg;
    typedef enum logic [1:0] {NONE, ODD, EVEN} parity_e;
    localparam int FRAME_WD = 8;
    localparam int CNT_WD = 8;
    typedef logic [FRAME_WD-1:0] frame_t;
endpackage

// File: rtl/uart_sat_cnt.sv
// uart_sat_cnt: saturating event counter, cleared only by reset.
module uart_sat_cnt
    import uart_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc,
    output logic [CNT_WD-1:0] cnt
);
    logic [CNT_WD-1:0] cnt_q, cnt_d;

    always_comb cnt_d = (inc && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;

    assign cnt = cnt_q;
endmodule

// File: rtl/uart_loop_buf.sv
// uart_loop_buf: rx-to-tx elastic FIFO with error drop and overflow/drop counters.
module uart_loop_buf
    import uart_pkg::*;
#(
    parameter int FRAME_WD = uart_pkg::FRAME_WD,
    parameter int DEPTH    = 16,
    parameter bit DROP_ERR = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [FRAME_WD-1:0]      rx_data,
    input  logic                     rx_valid,
    input  logic                     rx_err,
    output logic [FRAME_WD-1:0]      tx_data,
    output logic                     tx_valid,
    input  logic                     tx_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty,
    output logic [CNT_WD-1:0]        ovf_cnt,
    output logic [CNT_WD-1:0]        drop_cnt
);
    localparam int AW = $clog2(DEPTH);

    logic [FRAME_WD-1:0] mem_q [DEPTH];
    logic [AW:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic                pop, push_req, wr_en, ovf, drop;

    always_comb begin
        level    = wr_ptr_q - rd_ptr_q;
        full     = level == (AW+1)'(DEPTH);
        empty    = level == '0;
        tx_valid = !empty;
        pop      = tx_valid && tx_ready;
        push_req = rx_valid && !(rx_err && DROP_ERR);
        drop     = rx_valid && rx_err && DROP_ERR;
        // a pop in the same cycle frees the slot, so a full buffer still accepts
        wr_en    = push_req && (!full || pop);
        ovf      = push_req && full && !pop;
        wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end

    always_ff @(posedge clk)
        if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= rx_data;

    assign tx_data = mem_q[rd_ptr_q[AW-1:0]];

    uart_sat_cnt u_ovf_cnt  (.clk(clk), .rst_n(rst_n), .inc(ovf),  .cnt(ovf_cnt));
    uart_sat_cnt u_drop_cnt (.clk(clk), .rst_n(rst_n), .inc(drop), .cnt(drop_cnt));
endmodule

// File: doc/uart_loop_buf.md
# uart_loop_buf

Receive-to-transmit elastic buffer for the UART loopback path. Sits between the receiver, which produces one-cycle frame strobes, and the transmitter, which consumes frames via a valid/ready handshake. It absorbs back-pressure while the transmitter is busy sending a frame. It drops frames flagged bad by the receiver and counts both drops and overflows.

## Interface
- `FRAME_WD`, default 8: data bits per frame.
- `DEPTH`, default 16: buffer entries; must be a power of 2 and at least 2.
- `DROP_ERR`, default 1: 1 means frames with `rx_err` are discarded; 0 means they are stored like any other frame.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rx_data`  in  FRAME_WD  received frame payload, LSB = first bit on the line.
- `rx_valid`  in  1  one-cycle strobe: `rx_data`/`rx_err` are valid.
- `rx_err`  in  1  parity or stop-bit error for the current strobe.
- `tx_data`  out  FRAME_WD  head-of-buffer frame.
- `tx_valid`  out  1  buffer non-empty.
- `tx_ready`  in  1  transmitter accepts `tx_data` this cycle.
- `level`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- `full`  out  1  `level == DEPTH`.
- `empty`  out  1  `level == 0`.
- `ovf_cnt`  out  8  frames lost to a full buffer; saturates at 255.
- `drop_cnt`  out  8  frames discarded for `rx_err`; saturates at 255.

## Operation
- Storage is a circular array of DEPTH words. Write and read pointers are $clog2(DEPTH)+1 bits wide; the extra MSB distinguishes full from empty.
- Pop: occurs when `tx_valid && tx_ready`; the read pointer increments.
- Push request: occurs when `rx_valid && !(rx_err && DROP_ERR)`.
- Error drop: `rx_valid && rx_err && DROP_ERR` increments `drop_cnt` and writes nothing.
- Push when not full: data is written at the write pointer and the write pointer increments.
- Push when full:
  - With a pop in the same cycle, the push is accepted and `level` is unchanged.
  - Without a pop, the frame is discarded and `ovf_cnt` increments.
- Push while empty: there is no bypass; the frame becomes visible the following cycle.
- `tx_data` reads the array combinationally at the read pointer (first-word fall-through). It is undefined when `empty`, and the transmitter must ignore it then.
- `tx_ready` while `empty` has no effect.
- `level` is the write pointer minus the read pointer, modulo 2^($clog2(DEPTH)+1). Pointers wrap naturally.
- Both counters saturate at 255 and never wrap. They clear only on reset.
- No state machine beyond the pointer pair and the counters.

## Timing
- Reset (asynchronous assert, synchronous release by design):
  - Pointers = 0, `level` = 0, `empty` = 1, `full` = 0, `tx_valid` = 0, `ovf_cnt` = 0, `drop_cnt` = 0.
  - The array is not reset; `tx_data` is don't-care.
- Push latency: a strobe sampled at edge N gives `tx_valid` = 1 and the correct `tx_data` after edge N. The frame is poppable at edge N+1.
- Pop: handshake at edge N; the next entry (or `empty`) is presented after edge N.
- `full`, `empty` and `level` are registered-state derived and change only after clock edges. There is no combinational path from `rx_*` to any output.
- There is a combinational path from the read pointer to `tx_data` only. `tx_ready` does not combinationally affect any output.
- Reset mid-operation: all contents are lost immediately. Any frame in flight in the transmitter is the transmitter's concern.
- Back-to-back `rx_valid` strobes on consecutive cycles must be accepted; each pushes one entry.

## Structure
- Shared package `uart_pkg`: parity enum (`NONE`/`ODD`/`EVEN`), default `FRAME_WD`, `CNT_WD = 8`, and a `frame_t` typedef.
- One sub-module, `uart_sat_cnt`: 8-bit saturating counter with increment enable and async active-low reset. It is instantiated twice, for overflow and drop counting.

## Test plan
- Reset, then a single strobe with `rx_data = 0xD5`, `rx_err = 0`, and `tx_ready = 0`:
  - Next cycle: `tx_valid = 1`, `tx_data = 0xD5`, `level = 1`.
  - Then assert `tx_ready` for one cycle: `empty = 1`.
- Strobes with 0xD5, then 0x91, while `tx_ready = 0`; then hold `tx_ready = 1` → pops in order 0xD5 then 0x91, after which `level = 0`.
- Push 17 frames (0x00..0x10) with `tx_ready = 0` and `DEPTH = 16`:
  - `full = 1`, `level = 16`, `ovf_cnt = 1`.
  - Draining yields 0x00..0x0F; 0x10 is absent.
- While full, issue a strobe with 0xAA in the same cycle as a pop → `ovf_cnt` unchanged, `level = 16`, and 0xAA comes out last.
- Strobe with `rx_err = 1`, `DROP_ERR = 1` → `drop_cnt = 1`, `level` unchanged. Repeat 300 times → `drop_cnt = 255`. With `DROP_ERR = 0`, the same strobe is stored.
- Fill to 8 entries, then assert `rst_n = 0` between edges:
  - `empty = 1` and counters read 0 immediately, with no clock edge needed.
  - After release, push 0x91 → it is the first frame popped.
